// File: rtl/mc14500b_pkg.sv
// Shared types for the MC14500B program-counter sequencer.
package mc14500b_pkg;
    typedef enum logic [1:0] {IDLE, RUN, LOAD, HALT} seq_state_t;
    localparam logic SEQ_UP = 1'b1;
endpackage

// File: rtl/mc14500b_ret_stack.sv
// LIFO return-address stack; dout shows the top entry whenever non-empty.
module mc14500b_ret_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [CNT_W-1:0]  count;
    logic [IDX_W-1:0]  wr_idx, top_idx;

    assign wr_idx  = IDX_W'(count);
    assign top_idx = IDX_W'(count - CNT_W'(1));
    assign full    = (count == CNT_W'(STACK_DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[top_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (push && !full)
            count <= count + CNT_W'(1);
        else if (pop && !empty)
            count <= count - CNT_W'(1);
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push && !full)
            mem[wr_idx] <= din;
    end
endmodule

// File: rtl/mc14500b_pc_sequencer.sv
// Drives the MC14516B counter chain's preset/count pins from ICU JMP/RTN/FLGF strobes,
// with a call/return stack, post-return skip and halt at the top address.
module mc14500b_pc_sequencer
    import mc14500b_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              jmp,
    input  logic              rtn,
    input  logic              flag_f,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] cnt_preset,
    output logic              cnt_preset_enable,
    output logic              cnt_carry_in,
    output logic              cnt_up_down,
    output logic              skip,
    output logic              halted,
    output logic              stack_err
);
    seq_state_t        state, state_nxt;
    logic [ADDR_W-1:0] preset_nxt, stk_top;
    logic              pe_nxt, cin_nxt, skip_nxt, halted_nxt, err_nxt;
    logic              ret_flag, ret_nxt;
    logic              push, pop, stk_full, stk_empty, pc_max;

    assign pc_max      = &pc;
    assign cnt_up_down = SEQ_UP;

    mc14500b_ret_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc),
        .dout  (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        state_nxt  = state;
        preset_nxt = cnt_preset;
        pe_nxt     = 1'b0;
        cin_nxt    = cnt_carry_in;
        skip_nxt   = 1'b0;
        halted_nxt = halted;
        err_nxt    = stack_err;
        ret_nxt    = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                cin_nxt = 1'b1;
                if (run) begin
                    state_nxt = RUN;
                    cin_nxt   = 1'b0;
                end
            end
            RUN: begin
                cin_nxt = 1'b0;
                if (jmp) begin
                    state_nxt  = LOAD;
                    preset_nxt = target;
                    pe_nxt     = 1'b1;
                    cin_nxt    = 1'b1;
                    if (flag_f) begin
                        if (stk_full) err_nxt = 1'b1;
                        else          push    = 1'b1;
                    end
                end else if (rtn && !stk_empty) begin
                    state_nxt  = LOAD;
                    preset_nxt = stk_top;
                    pop        = 1'b1;
                    pe_nxt     = 1'b1;
                    cin_nxt    = 1'b1;
                    ret_nxt    = 1'b1;
                end else if (rtn) begin
                    err_nxt = 1'b1;
                end else if (!run) begin
                    state_nxt = IDLE;
                    cin_nxt   = 1'b1;
                end else if (pc_max) begin
                    // Stop at the top address instead of letting the counter wrap.
                    state_nxt  = HALT;
                    halted_nxt = 1'b1;
                    cin_nxt    = 1'b1;
                end
            end
            LOAD: begin
                // The returned-to address is the calling JMP itself; the ICU must skip it.
                skip_nxt  = ret_flag;
                state_nxt = run ? RUN : IDLE;
                cin_nxt   = !run;
            end
            HALT: begin
                halted_nxt = 1'b1;
                cin_nxt    = 1'b1;
                if (!run) begin
                    state_nxt  = IDLE;
                    halted_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cin_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            cnt_preset        <= '0;
            cnt_preset_enable <= 1'b0;
            cnt_carry_in      <= 1'b1;
            skip              <= 1'b0;
            halted            <= 1'b0;
            stack_err         <= 1'b0;
            ret_flag          <= 1'b0;
        end else begin
            state             <= state_nxt;
            cnt_preset        <= preset_nxt;
            cnt_preset_enable <= pe_nxt;
            cnt_carry_in      <= cin_nxt;
            skip              <= skip_nxt;
            halted            <= halted_nxt;
            stack_err         <= err_nxt;
            ret_flag          <= ret_nxt;
        end
    end
endmodule
